e_xlu: RTL and testbench
========================

Name: e_xlu

Overview:
- Multiply/divide unit in the E stage; it executes the 4-bit xlu_op code the E-stage controller issues.
- Holds the architectural HI/LO registers.
- Runs multi-cycle mult/div/madd/msub operations and drives busy/start so the hazard unit can stall later HI/LO users.
- Serves mfhi/mflo read data to the E-stage result mux.

Parameters:
MUL_CYCLES, 5, cycles from issue to HI/LO commit for mult/multu/madd/maddu/msub/msubu (≥1)
DIV_CYCLES, 10, cycles from issue to HI/LO commit for div/divu (≥1)

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low; clears all state
xlu_op  input  4  op code from E-stage controller
a  input  32  forwarded rs value
b  input  32  forwarded rt value
start  output  1  combinational; 1 when xlu_op is a multi-cycle op (0000–0011, 1001–1100) and busy=0
busy  output  1  registered; 1 while an operation is in flight
hi  output  32  HI register
lo  output  32  LO register
rd_data  output  32  combinational; hi when xlu_op=0110, lo when xlu_op=0111, else 0

Behaviour:
- Op codes:
  - 0000 mult, 0001 multu, 0010 div, 0011 divu
  - 0100 mthi, 0101 mtlo, 0110 mfhi, 0111 mflo
  - 1000 none
  - 1001 madd, 1010 maddu, 1011 msub, 1100 msubu
  - 1101–1111 treated as none
- Reset (reset=0, async): hi=0, lo=0, busy=0, counter=0, pending result=0. start and rd_data follow their combinational definitions.
- Issue: at a rising edge with start=1:
  - latch the 64-bit result into pending {p_hi,p_lo};
  - load counter with MUL_CYCLES or DIV_CYCLES;
  - busy←1.
- In flight: counter decrements each edge. At the edge where counter goes 1→0: {hi,lo}←{p_hi,p_lo} and busy←0, on the same edge. An op issued at edge T commits at edge T+N; busy is high for exactly N cycles.
- While busy=1:
  - every xlu_op is ignored: no issue, no mthi/mtlo;
  - rd_data still reflects current (old) hi/lo;
  - the hazard unit guarantees no HI/LO-touching op reaches E while busy or start. The block does not queue.
- mthi/mtlo (busy=0): hi←a or lo←a at the next edge, single-cycle. busy is unaffected.
- Arithmetic:
  - mult: signed 32×32→64, {hi,lo}=product.
  - multu: same, unsigned.
  - div: signed; lo=quotient truncated toward zero, hi=remainder with the sign of the dividend a.
  - divu: same, unsigned.
  - b=0 for div/divu: full DIV_CYCLES latency, then hi/lo keep their prior values (no commit).
  - madd/maddu: {hi,lo}+=a×b (signed/unsigned product), 64-bit wraparound.
  - msub/msubu: {hi,lo}−=a×b, 64-bit wraparound.
  - The accumulate base is the {hi,lo} value at the issue edge.
- Signed overflow case: div 0x80000000/0xFFFFFFFF gives lo=0x80000000, hi=0.
- Reset mid-operation: the in-flight op is discarded, busy drops immediately, hi=lo=0.
- Simultaneous commit and new op: ops presented on the commit edge are ignored because busy=1 at that edge. They are accepted from the next edge.

Test Plan:
- Reset with busy mid-div (reset low at cycle 4) → busy=0, hi=lo=0 asynchronously; no commit afterwards.
- mult a=0xFFFFFFFF b=2 → start=1 at cycle 0, busy=1 for cycles 1–5, then hi=0xFFFFFFFF, lo=0xFFFFFFFE. multu with the same operands → hi=0x00000001, lo=0xFFFFFFFE.
- div a=0xFFFFFFF9 (−7) b=2 → after 10 cycles lo=0xFFFFFFFD, hi=0xFFFFFFFF. divu a=7 b=2 → lo=3, hi=1. div by b=0 → hi/lo unchanged after 10 cycles.
- mthi 0x0, mtlo 0xFFFFFFFF, then madd 1×1 → hi=0x00000001, lo=0x00000000. Then msubu 1×1 → hi=0, lo=0xFFFFFFFF.
- mtlo 0x1234 issued while busy → lo unchanged. After commit, mflo → rd_data=committed lo. mthi 0xABCD with busy=0 → hi=0xABCD next cycle, busy stays 0.
- xlu_op=1000 and 1101–1111 → start=0, rd_data=0, no state change.

Source files
------------

// File: rtl/e_xlu.sv
// e_xlu: E-stage multiply/divide unit that owns the architectural HI/LO pair.
// Multi-cycle ops (mult/div/madd/msub families) compute their 64-bit result at
// issue, hold it as a pending value, and commit it to HI/LO after a fixed
// latency. busy covers the in-flight window so the hazard unit can stall.
//
// Ports:
//   clk      system clock, rising edge
//   reset    asynchronous, active-low; clears HI/LO, busy and pending state
//   xlu_op   4-bit op code from the E-stage controller
//   a, b     forwarded rs / rt operands
//   start    combinational; a multi-cycle op is being accepted this cycle
//   busy     registered; an operation is in flight
//   hi, lo   architectural HI / LO registers
//   rd_data  combinational; mfhi/mflo read data, 0 for every other op
module e_xlu #(
  parameter int unsigned MUL_CYCLES = 5,
  parameter int unsigned DIV_CYCLES = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  xlu_op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        start,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic [31:0] rd_data
);

  localparam int unsigned MAX_CYCLES = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
  localparam int unsigned CNT_W      = $clog2(MAX_CYCLES + 1);

  localparam logic [3:0] OP_MULT  = 4'b0000;
  localparam logic [3:0] OP_MULTU = 4'b0001;
  localparam logic [3:0] OP_DIV   = 4'b0010;
  localparam logic [3:0] OP_DIVU  = 4'b0011;
  localparam logic [3:0] OP_MTHI  = 4'b0100;
  localparam logic [3:0] OP_MTLO  = 4'b0101;
  localparam logic [3:0] OP_MFHI  = 4'b0110;
  localparam logic [3:0] OP_MFLO  = 4'b0111;
  localparam logic [3:0] OP_MADD  = 4'b1001;
  localparam logic [3:0] OP_MADDU = 4'b1010;
  localparam logic [3:0] OP_MSUB  = 4'b1011;
  localparam logic [3:0] OP_MSUBU = 4'b1100;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [63:0]      pend_q;

  logic        is_multi, is_div;
  logic        issue, commit;
  logic [63:0] acc, a_sx, b_sx, prod_s, prod_u;
  logic [31:0] ua, ub, ub_safe, uq, ur, quot, rem;
  logic        div_signed, div_zero;
  logic [63:0] result;

  // Op decode: which codes start a multi-cycle operation.
  always_comb begin
    is_multi = 1'b0;
    is_div   = 1'b0;
    case (xlu_op)
      OP_MULT, OP_MULTU, OP_MADD, OP_MADDU, OP_MSUB, OP_MSUBU: is_multi = 1'b1;
      OP_DIV, OP_DIVU: begin
        is_multi = 1'b1;
        is_div   = 1'b1;
      end
      default: ;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Next state: accept a multi-cycle op when idle, return when the count expires.
  always_comb begin
    state_d = state_q;
    issue   = 1'b0;
    commit  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (is_multi) begin
          issue   = 1'b1;
          state_d = ST_BUSY;
        end
      end
      ST_BUSY: begin
        if (cnt_q == CNT_W'(1)) begin
          commit  = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign start = issue;
  assign busy  = (state_q == ST_BUSY);

  // Read port for mfhi/mflo; reflects current HI/LO even while busy.
  always_comb begin
    rd_data = 32'd0;
    if (xlu_op == OP_MFHI)      rd_data = hi;
    else if (xlu_op == OP_MFLO) rd_data = lo;
  end

  // Products: truncating 64x64 to 64 bits gives the exact 32x32 result.
  always_comb begin
    acc    = {hi, lo};
    a_sx   = {{32{a[31]}}, a};
    b_sx   = {{32{b[31]}}, b};
    prod_s = a_sx * b_sx;
    prod_u = {32'd0, a} * {32'd0, b};
  end

  // Division on magnitudes so 0x80000000 / -1 needs no special case;
  // signs are reapplied afterwards (quotient toward zero, remainder follows a).
  always_comb begin
    div_signed = (xlu_op == OP_DIV);
    div_zero   = (b == 32'd0);
    ua         = (div_signed && a[31]) ? 32'(-a) : a;
    ub         = (div_signed && b[31]) ? 32'(-b) : b;
    ub_safe    = div_zero ? 32'd1 : ub;
    uq         = ua / ub_safe;
    ur         = ua % ub_safe;
    quot       = (div_signed && (a[31] ^ b[31])) ? 32'(-uq) : uq;
    rem        = (div_signed && a[31]) ? 32'(-ur) : ur;
  end

  // Pending result; divide-by-zero re-commits the current HI/LO unchanged.
  always_comb begin
    result = acc;
    case (xlu_op)
      OP_MULT:         result = prod_s;
      OP_MULTU:        result = prod_u;
      OP_DIV, OP_DIVU: result = div_zero ? acc : {rem, quot};
      OP_MADD:         result = acc + prod_s;
      OP_MADDU:        result = acc + prod_u;
      OP_MSUB:         result = acc - prod_s;
      OP_MSUBU:        result = acc - prod_u;
      default:         result = acc;
    endcase
  end

  // Latency counter, pending result and HI/LO registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q  <= '0;
      pend_q <= '0;
      hi     <= '0;
      lo     <= '0;
    end else begin
      if (issue) begin
        pend_q <= result;
        cnt_q  <= is_div ? CNT_W'(DIV_CYCLES) : CNT_W'(MUL_CYCLES);
      end else if (state_q == ST_BUSY) begin
        cnt_q <= cnt_q - CNT_W'(1);
      end

      if (commit) begin
        hi <= pend_q[63:32];
        lo <= pend_q[31:0];
      end else if (state_q == ST_IDLE) begin
        if (xlu_op == OP_MTHI) hi <= a;
        if (xlu_op == OP_MTLO) lo <= a;
      end
    end
  end

endmodule

// File: tb/tb_e_xlu.sv
// Directed bench for e_xlu: hand-computed HI/LO results and busy/start timing.
module tb_e_xlu;

  localparam int unsigned MUL_N = 5;
  localparam int unsigned DIV_N = 10;

  logic        clk;
  logic        reset;
  logic [3:0]  xlu_op;
  logic [31:0] a;
  logic [31:0] b;
  logic        start;
  logic        busy;
  logic [31:0] hi;
  logic [31:0] lo;
  logic [31:0] rd_data;

  int tests_run;
  int tests_failed;

  e_xlu #(.MUL_CYCLES(MUL_N), .DIV_CYCLES(DIV_N)) dut (
    .clk     (clk),
    .reset   (reset),
    .xlu_op  (xlu_op),
    .a       (a),
    .b       (b),
    .start   (start),
    .busy    (busy),
    .hi      (hi),
    .lo      (lo),
    .rd_data (rd_data)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issue one multi-cycle op, check busy for n cycles, then the committed HI/LO.
  task automatic run_op(input string tag, input logic [3:0] op, input logic [31:0] oa,
                        input logic [31:0] ob, input int n,
                        input logic [31:0] ehi, input logic [31:0] elo);
    xlu_op = op; a = oa; b = ob;
    #1;
    chk({tag, "_start"}, {31'd0, start}, 32'd1);
    step();
    xlu_op = 4'b1000;
    chk({tag, "_busy1"}, {31'd0, busy}, 32'd1);
    for (int i = 1; i < n; i++) begin
      step();
      chk({tag, "_busyN"}, {31'd0, busy}, 32'd1);
    end
    step();
    chk({tag, "_done"}, {31'd0, busy}, 32'd0);
    chk({tag, "_hi"}, hi, ehi);
    chk({tag, "_lo"}, lo, elo);
  endtask

  initial begin
    logic [3:0] none_ops [4];
    none_ops[0] = 4'b1000; none_ops[1] = 4'b1101;
    none_ops[2] = 4'b1110; none_ops[3] = 4'b1111;
    tests_run = 0;
    tests_failed = 0;

    // Reset state
    reset = 1'b0; xlu_op = 4'b1000; a = '0; b = '0;
    #2;
    chk("rst_hi", hi, 32'd0);
    chk("rst_lo", lo, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_start", {31'd0, start}, 32'd0);
    chk("rst_rd", rd_data, 32'd0);
    step();
    reset = 1'b1;

    // Multiply
    run_op("mult",  4'b0000, 32'hFFFF_FFFF, 32'd2, MUL_N, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
    run_op("multu", 4'b0001, 32'hFFFF_FFFF, 32'd2, MUL_N, 32'h0000_0001, 32'hFFFF_FFFE);

    // Divide
    run_op("div",   4'b0010, 32'hFFFF_FFF9, 32'd2, DIV_N, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    run_op("divu",  4'b0011, 32'd7,         32'd2, DIV_N, 32'd1,         32'd3);
    run_op("div0",  4'b0010, 32'd5,         32'd0, DIV_N, 32'd1,         32'd3);
    run_op("divov", 4'b0010, 32'h8000_0000, 32'hFFFF_FFFF, DIV_N, 32'd0, 32'h8000_0000);

    // mthi / mtlo then accumulate
    xlu_op = 4'b0100; a = 32'h0;
    #1;
    chk("mthi_start", {31'd0, start}, 32'd0);
    step();
    chk("mthi_hi", hi, 32'd0);
    chk("mthi_busy", {31'd0, busy}, 32'd0);
    xlu_op = 4'b0101; a = 32'hFFFF_FFFF;
    step();
    chk("mtlo_lo", lo, 32'hFFFF_FFFF);
    xlu_op = 4'b1000;
    run_op("madd",  4'b1001, 32'd1, 32'd1, MUL_N, 32'd1, 32'd0);
    run_op("msubu", 4'b1100, 32'd1, 32'd1, MUL_N, 32'd0, 32'hFFFF_FFFF);
    run_op("msub",  4'b1011, 32'hFFFF_FFFF, 32'd2, MUL_N, 32'd1, 32'd1);
    run_op("maddu", 4'b1010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, MUL_N, 32'hFFFF_FFFF, 32'd2);

    // Ops presented while busy (including the commit edge) are ignored
    xlu_op = 4'b0000; a = 32'd3; b = 32'd5;
    #1;
    chk("busyop_start", {31'd0, start}, 32'd1);
    step();
    xlu_op = 4'b0111;
    #1;
    chk("busy_rd_lo", rd_data, 32'd2);
    xlu_op = 4'b0000;
    #1;
    chk("busy_nostart", {31'd0, start}, 32'd0);
    xlu_op = 4'b0101; a = 32'h1234;
    for (int i = 1; i < int'(MUL_N); i++) begin
      step();
      chk("busy_lo_hold", lo, 32'd2);
    end
    step();
    xlu_op = 4'b0111;
    chk("busy_commit_busy", {31'd0, busy}, 32'd0);
    chk("busy_commit_lo", lo, 32'd15);
    chk("busy_commit_hi", hi, 32'd0);
    #1;
    chk("mflo_rd", rd_data, 32'd15);
    xlu_op = 4'b0100; a = 32'hABCD;
    #1;
    chk("mthi2_start", {31'd0, start}, 32'd0);
    step();
    chk("mthi2_hi", hi, 32'hABCD);
    chk("mthi2_busy", {31'd0, busy}, 32'd0);
    xlu_op = 4'b0110;
    #1;
    chk("mfhi_rd", rd_data, 32'hABCD);

    // No-op codes
    for (int i = 0; i < 4; i++) begin
      xlu_op = none_ops[i]; a = 32'h5A5A_5A5A; b = 32'h1;
      #1;
      chk("none_start", {31'd0, start}, 32'd0);
      chk("none_rd", rd_data, 32'd0);
      step();
      chk("none_hi", hi, 32'hABCD);
      chk("none_lo", lo, 32'd15);
      chk("none_busy", {31'd0, busy}, 32'd0);
    end

    // Reset mid-divide: discard in-flight op, no later commit
    xlu_op = 4'b0010; a = 32'd100; b = 32'd7;
    #1;
    chk("rdiv_start", {31'd0, start}, 32'd1);
    step();
    xlu_op = 4'b1000;
    step(); step(); step();
    chk("rdiv_busy_pre", {31'd0, busy}, 32'd1);
    #2;
    reset = 1'b0;
    #1;
    chk("rdiv_busy", {31'd0, busy}, 32'd0);
    chk("rdiv_hi", hi, 32'd0);
    chk("rdiv_lo", lo, 32'd0);
    step();
    reset = 1'b1;
    repeat (DIV_N + 2) step();
    chk("rdiv_after_hi", hi, 32'd0);
    chk("rdiv_after_lo", lo, 32'd0);
    chk("rdiv_after_busy", {31'd0, busy}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
